// File: rtl/sram_controller.sv
// sram_controller: memory-stage responder that splits each 32-bit word access
// into two sequential halfword accesses (low, then high) of an external 16-bit
// asynchronous SRAM. ready is held low while an access is in flight.
// Optional macro SRAM_ADDR_CHECK_EN: reject out-of-range or misaligned requests
// (no SRAM strobe, addr_err=1 in DONE). Without it, addr_err is tied to 0 and
// the word index wraps modulo the SRAM size.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   addr_err
);

  localparam int IDX_W = SRAM_ADDR_W - 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_wr;
  logic [IDX_W-1:0]       r_idx;
  logic [15:0]            r_wdata_hi;
  logic [31:0]            r_rdata;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [15:0]            r_dq_out;
  logic                   r_dq_oe;
  logic                   r_we_n;

  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic             w_req;
  logic             w_last;
  logic             w_reject;
  logic             w_unused_bits;

  // Word index is the byte offset from BASE_ADDR, truncated so accesses wrap.
  assign w_offset      = address - BASE_ADDR;
  assign w_idx         = w_offset[IDX_W+1:2];
  assign w_req         = rd_en | wr_en;
  assign w_last        = (r_cnt == LAST_CNT);
  assign w_unused_bits = ^{w_offset[31:IDX_W+2], w_offset[1:0]};

  assign ready       = ~w_req | (r_state == S_DONE);
  assign read_data   = r_rdata;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

`ifdef SRAM_ADDR_CHECK_EN
  logic r_err;

  assign w_reject = (address < BASE_ADDR) | (address[1:0] != 2'b00) |
                    (|w_offset[31:IDX_W+2]);
  assign addr_err = r_err;

  // Error flag is raised for exactly the DONE cycle of a rejected request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_err <= 1'b0;
    else if (r_state == S_IDLE && w_req && w_reject) r_err <= 1'b1;
    else if (r_state == S_DONE)                      r_err <= 1'b0;
  end
`else
  assign w_reject = 1'b0;
  assign addr_err = 1'b0;
`endif

  // Main FSM; SRAM pins are registered and updated on the edge that enters each
  // phase so they are stable for the whole phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_idx       <= '0;
      r_wdata_hi  <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_cnt <= '0;
            if (w_reject) begin
              r_state <= S_DONE;
            end else begin
              r_state     <= S_LOW;
              r_wr        <= wr_en;
              r_idx       <= w_idx;
              r_wdata_hi  <= write_data[31:16];
              r_sram_addr <= {w_idx, 1'b0};
              r_dq_out    <= write_data[15:0];
              r_dq_oe     <= wr_en;
              r_we_n      <= ~wr_en;
            end
          end
        end
        S_LOW: begin
          if (w_last) begin
            r_cnt       <= '0;
            r_state     <= S_HIGH;
            r_sram_addr <= {r_idx, 1'b1};
            r_dq_out    <= r_wdata_hi;
            if (!r_wr) r_rdata[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            if (!r_wr) r_rdata[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: behavioural 16-bit SRAM device plus a word-level
// reference memory; randomized accesses checked against expected phase layout,
// latency and returned data.
module tb_sram_controller;

  localparam int W = 1;
  localparam int N = 2 * W + 3;   // cycle in which ready rises

  logic        clk, rst, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_dq_oe, sram_we_n, addr_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  sram_controller #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM device
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  // Reference: word-indexed memory
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd;
  int checks = 0, errors = 0;

  // Per-cycle trace of the last access
  logic [17:0] t_addr [0:N];
  logic [15:0] t_dq   [0:N];
  logic        t_we   [0:N];
  logic        t_oe   [0:N];
  logic        t_rdy  [0:N];
  logic        t_err  [0:N];
  logic [31:0] t_rd   [0:N];

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 4) % 131072);
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic snap(input int c);
    t_addr[c] = sram_addr; t_dq[c] = sram_dq_out; t_we[c] = sram_we_n;
    t_oe[c] = sram_dq_oe; t_rdy[c] = ready; t_err[c] = addr_err; t_rd[c] = read_data;
  endtask

  // Drive one request starting in an IDLE cycle and record cycles 0..N.
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input int drop_at);
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1 snap(0);
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      snap(c);
      if (c == drop_at) begin wr_en = 1'b0; rd_en = 1'b0; end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    if (wr) ref_mem[word_idx(a)] = d;
    else    exp_rd = ref_word(word_idx(a));
  endtask

  task automatic test_reset;
    rst = 1'b0; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 ||
        sram_dq_out !== 16'd0 || read_data !== 32'd0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we_n=%b oe=%b addr=%h dq=%h rd=%h err=%b, need 1 1 0 0 0 0 0",
               ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data, addr_err);
    end
    rst = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1024 + 32'd400; write_data = 32'h11112222;
    repeat (2) @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0) begin
      errors++; $display("FAIL reset_prewrite_strobe: we_n=%b need 0", sram_we_n);
    end
    rst = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midwrite: we_n=%b oe=%b addr=%h rdy=%b, need 1 0 0 1",
               sram_we_n, sram_dq_oe, sram_addr, ready);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_rd = 32'h0;
  endtask

  task automatic test_load;
    sram_mem[0] = 16'h5678; sram_mem[1] = 16'h1234;
    ref_mem[0] = 32'h12345678;
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
    for (int c = 0; c <= N; c++) begin
      checks++;
      if (t_we[c] !== 1'b1 || t_oe[c] !== 1'b0 || t_rdy[c] !== (c == N)) begin
        errors++;
        $display("FAIL load_cycle%0d: we_n=%b oe=%b rdy=%b, need 1 0 %0d", c, t_we[c], t_oe[c], t_rdy[c], c == N);
      end
    end
    checks++;
    if (t_rd[N] !== 32'h12345678) begin
      errors++; $display("FAIL load_data: got %h need 12345678", t_rd[N]);
    end
  endtask

  task automatic test_store;
    logic [31:0] prev;
    prev = exp_rd;
    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1);
    for (int c = 1; c < N; c++) begin
      checks++;
      if (t_addr[c] !== ((c <= W + 1) ? 18'd0 : 18'd1) ||
          t_dq[c] !== ((c <= W + 1) ? 16'hBEEF : 16'hDEAD) || t_we[c] !== 1'b0 || t_oe[c] !== 1'b1) begin
        errors++;
        $display("FAIL store_cycle%0d: addr=%h dq=%h we_n=%b oe=%b", c, t_addr[c], t_dq[c], t_we[c], t_oe[c]);
      end
    end
    for (int c = 0; c <= N; c++) begin
      checks++;
      if (t_rdy[c] !== (c == N)) begin
        errors++; $display("FAIL store_ready%0d: got %b need %0d", c, t_rdy[c], c == N);
      end
    end
    checks++;
    if (t_we[N] !== 1'b1 || t_rd[N] !== prev) begin
      errors++; $display("FAIL store_done: we_n=%b rd=%h, need 1 %h", t_we[N], t_rd[N], prev);
    end
    exp_rd = prev;
  endtask

  task automatic test_addr_map;
    do_access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, -1);
    checks++;
    if (t_addr[1] !== 18'd4 || t_addr[N-1] !== 18'd5 || sram_mem[4] !== 16'hF00D || sram_mem[5] !== 16'hCAFE) begin
      errors++;
      $display("FAIL addr_map_store: addr %h/%h mem %h/%h, need 4/5 f00d/cafe",
               t_addr[1], t_addr[N-1], sram_mem[4], sram_mem[5]);
    end
    do_access(1'b0, 1'b1, 32'd1032, 32'h0, -1);
    checks++;
    if (t_rd[N] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL addr_map_load: got %h need cafef00d", t_rd[N]);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    d = $urandom;
    do_access(1'b1, 1'b1, 32'd1036, d, -1);
    checks++;
    if (t_we[1] !== 1'b0 || t_dq[1] !== d[15:0] || t_dq[N-1] !== d[31:16]) begin
      errors++; $display("FAIL simul_as_write: we_n=%b dq=%h/%h need 0 %h/%h", t_we[1], t_dq[1], t_dq[N-1], d[15:0], d[31:16]);
    end
    do_access(1'b0, 1'b1, 32'd1036, 32'h0, -1);
    checks++;
    if (t_rd[N] !== d) begin
      errors++; $display("FAIL simul_readback: got %h need %h", t_rd[N], d);
    end
  endtask

  task automatic test_drop;
    logic [31:0] d;
    d = $urandom;
    do_access(1'b1, 1'b0, 32'd1040, d, 2);
    checks++;
    if (t_addr[N-1] !== 18'd9 || t_we[N-1] !== 1'b0 || t_rdy[N] !== 1'b1 || t_we[N] !== 1'b1) begin
      errors++;
      $display("FAIL drop_complete: hi addr=%h we_n=%b rdy5=%b we5=%b need 9 0 1 1", t_addr[N-1], t_we[N-1], t_rdy[N], t_we[N]);
    end
    do_access(1'b0, 1'b1, 32'd1040, 32'h0, -1);
    checks++;
    if (t_rd[N] !== d) begin
      errors++; $display("FAIL drop_readback: got %h need %h", t_rd[N], d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, a2;
    a1 = 32'd1024 + 32'd4 * 32'($urandom_range(0, 63));
    a2 = 32'd1024 + 32'd4 * 32'($urandom_range(0, 63));
    @(negedge clk);
    rd_en = 1'b1; address = a1;
    repeat (N) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || read_data !== ref_word(word_idx(a1))) begin
      errors++; $display("FAIL b2b_first: rdy=%b rd=%h need 1 %h", ready, read_data, ref_word(word_idx(a1)));
    end
    address = a2;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: rdy=%b need 0", ready);
    end
    repeat (N) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || read_data !== ref_word(word_idx(a2))) begin
      errors++; $display("FAIL b2b_second: rdy=%b rd=%h need 1 %h", ready, read_data, ref_word(word_idx(a2)));
    end
    rd_en = 1'b0;
    exp_rd = ref_word(word_idx(a2));
  endtask

  task automatic test_random;
    logic        wr;
    logic [31:0] a, d, prev;
    int          idx, lat;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
`ifdef SRAM_ADDR_CHECK_EN
      a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 63));
`else
      a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 63)) + (($urandom_range(0, 3) == 0) ? 32'd524288 : 32'd0);
`endif
      idx  = word_idx(a);
      prev = exp_rd;
      do_access(wr, ~wr, a, d, -1);
      lat = -1;
      for (int c = N; c >= 0; c--) if (t_rdy[c] === 1'b1) lat = c;
      checks++;
      if (lat != N) begin
        errors++; $display("FAIL rnd%0d_latency: ready first at %0d need %0d", i, lat, N);
      end
      checks++;
      if (t_addr[1] !== 18'(2 * idx) || t_addr[N-1] !== 18'(2 * idx + 1) ||
          t_we[1] !== ~wr || t_err[1] !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_phase: addr %h/%h we_n=%b err=%b need %h/%h %b 0", i, t_addr[1], t_addr[N-1],
                 t_we[1], t_err[1], 18'(2 * idx), 18'(2 * idx + 1), ~wr);
      end
      checks++;
      if (t_rd[N] !== (wr ? prev : exp_rd)) begin
        errors++; $display("FAIL rnd%0d_data: got %h need %h", i, t_rd[N], wr ? prev : exp_rd);
      end
      if (wr) exp_rd = prev;
    end
  endtask

`ifdef SRAM_ADDR_CHECK_EN
  task automatic test_addr_check;
    logic [31:0] bad [0:2];
    bad[0] = 32'd1026; bad[1] = 32'd1020; bad[2] = 32'd1024 + 32'd524288;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_en = 1'b1; address = bad[k];
      #1;
      checks++;
      if (ready !== 1'b0) begin
        errors++; $display("FAIL chk%0d_cycle0: rdy=%b need 0", k, ready);
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || addr_err !== 1'b1 || sram_we_n !== 1'b1 || read_data !== exp_rd) begin
        errors++;
        $display("FAIL chk%0d_reject: rdy=%b err=%b we_n=%b rd=%h need 1 1 1 %h", k, ready, addr_err, sram_we_n, read_data, exp_rd);
      end
      rd_en = 1'b0;
      @(negedge clk);
      checks++;
      if (addr_err !== 1'b0 || sram_we_n !== 1'b1) begin
        errors++; $display("FAIL chk%0d_after: err=%b we_n=%b need 0 1", k, addr_err, sram_we_n);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    exp_rd = 32'h0;
    test_reset;
    test_load;
    test_store;
    test_addr_map;
    test_simultaneous;
    test_drop;
    test_back_to_back;
    test_random;
`ifdef SRAM_ADDR_CHECK_EN
    test_addr_check;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
